mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised modulo up/down counter with prescaler, synchronous load/clear and a terminal-count/wrap indication. It generalises the free-running 3-bit test counter to arbitrary width and modulus, with direction control and an enable divided down by a programmable prescaler. Simulation benches and timing/sequencing logic use it wherever a bounded cycle or event count is needed.

## Interface
- `WIDTH`, 3: counter width in bits; must be ≥1.
- `MODULO`, 8: count range is 0..MODULO-1; must satisfy 2 ≤ MODULO ≤ 2^WIDTH.
- `PRESCALE`, 1: number of enabled cycles per count step; must be ≥1.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; advances the prescaler.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `clr`  in  1  synchronous clear of the counter and the prescaler.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  value to load.
- `cnt`  out  WIDTH  current count (registered).
- `next_cnt`  out  WIDTH  value `cnt` takes on the next step (combinational).
- `tick`  out  1  prescaler strobe; a step occurs this cycle (combinational).
- `done`  out  1  terminal count (combinational): `up ? cnt==MODULO-1 : cnt==0`.
- `wrap`  out  1  registered one-cycle pulse, boundary-crossing step.

## Operation
- Prescaler `pre` is `$clog2(PRESCALE)` bits (min 1). When `en`=1, it counts 0..PRESCALE-1 and then returns to 0. It holds when `en`=0.
- `tick = en && pre==PRESCALE-1`. With PRESCALE=1, `tick` equals `en`.
- `next_cnt`:
  - Up: `cnt==MODULO-1 ? 0 : cnt+1`.
  - Down: `cnt==0 ? MODULO-1 : cnt-1`.
  - Arithmetic is in WIDTH+1 bits, so no intermediate overflow occurs when MODULO=2^WIDTH.
- Per-edge priority: `clr` > `load` > step.
  - `clr`: `cnt`←0, `pre`←0, `wrap`←0.
  - `load`: `cnt`←`load_val`, clamped to MODULO-1 if larger; `pre`←0; `wrap`←0.
  - Step (on `tick`): `cnt`←`next_cnt`. `wrap`←1 if the step crossed a boundary (up from MODULO-1, or down from 0), else `wrap`←0.
  - No step: `cnt` holds, `wrap`←0.
- `up` may change on any cycle. It takes effect on the next step, and `done` follows it combinationally.

## Timing
- Reset (asynchronous assert, synchronous deassert by the user): `cnt`=0, `pre`=0, `wrap`=0.
  - `next_cnt` = `up` ? 1 : MODULO-1.
  - `tick` = `en` && PRESCALE==1.
  - `done` = !`up`.
- Reset asserted mid-count clears state immediately, with no clock needed.
- Latency: `tick` at edge N gives updated `cnt` visible after edge N. `wrap` is asserted in the same cycle `cnt` shows the wrapped value, for exactly one cycle.
- Back-to-back wraps (MODULO=2, PRESCALE=1, `en`=1): `wrap` is high every other cycle.
- `load`/`clr` coinciding with `tick` suppresses the step and forces `wrap`=0.
- `load` of MODULO-1 while up: `done`=1 on the following cycle.

## Configuration
- `MOD_COUNTER_SAT_EN`
  - Defined: saturating mode. A step at the boundary (up at MODULO-1, down at 0) leaves `cnt` unchanged, and `next_cnt` equals `cnt` there. `wrap` pulses for one cycle to flag the blocked step.
  - Undefined: wrap-around behaviour as described above.
  - Clamping of `load_val` applies in both modes.

## Test plan
- Defaults, `en`=1, `up`=1, run 20 cycles after reset → `cnt` 0,1,…,7,0,1,… with `done`=1 at `cnt`=7; `wrap`=1 only in cycles where `cnt` is 0 after 7.
- WIDTH=4, MODULO=10, `up`=0 from reset → `cnt` 0,9,8,…,0,9; `wrap` with each 0→9; `done`=1 whenever `cnt`=0.
- PRESCALE=3, `en`=1 → `cnt` increments every 3rd cycle, `tick` duty 1/3. Drop `en` for 5 cycles mid-period → `pre` and `cnt` hold, and the count resumes with the same phase.
- WIDTH=4, MODULO=10: `load_val`=12 with `load`=1 → `cnt`=9. Assert `load`+`clr` together → `cnt`=0. Assert `load` coincident with `tick` at `cnt`=9 → `cnt`=`load_val`, `wrap`=0.
- Assert `rst_n`=0 asynchronously between edges at `cnt`=5 → `cnt`=0 and `wrap`=0 immediately. Release → counting restarts from 0 with a full prescale period.
- With `MOD_COUNTER_SAT_EN`, defaults, `up`=1 for 12 cycles → `cnt` stops at 7 with `wrap` pulsing on each blocked step. Switch `up`=0 → `cnt` counts down to 0 and holds there.

Source files
------------

// File: rtl/mod_counter_if.sv
// mod_counter_if: control/status bundle between a counter and its user.
// Latency: none; plain wires, no storage.
// Backpressure: none; the user throttles the counter through en only.
interface mod_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] next_cnt;
    logic             tick;
    logic             done;
    logic             wrap;

    // user side: drives the controls, observes count and strobes
    modport master (
        output en, up, clr, load, load_val,
        input  cnt, next_cnt, tick, done, wrap
    );

    // counter side
    modport slave (
        input  en, up, clr, load, load_val,
        output cnt, next_cnt, tick, done, wrap
    );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULO up/down counter with prescaled enable, sync clear/load and wrap flag.
// Latency: cnt/wrap change one edge after tick; next_cnt, tick and done are combinational.
// Backpressure: none; dropping en freezes both prescaler and count.
// Build option: define MOD_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
// The connected interface instance must use the same WIDTH as this module.
module mod_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULO   = 8,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mod_counter_if.slave bus
);
    localparam int WP1 = WIDTH + 1;
    // prescaler is at least one bit wide so PRESCALE=1 still has a legal register
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // top of range, kept one bit wider so MODULO = 2^WIDTH compares cleanly
    localparam logic [WIDTH:0]   TOP_EXT  = WP1'(MODULO - 1);
    localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULO - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic [PW-1:0]    pre_q,  pre_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH:0]   cnt_ext;
    logic             at_top;
    logic             at_bot;
    logic             boundary;
    logic             tick;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] bnd_up_val;
    logic [WIDTH-1:0] bnd_dn_val;
    logic [WIDTH-1:0] next_cnt;
    logic [WIDTH-1:0] load_clamped;

    // step arithmetic, boundary detection, prescaler strobe and load clamp
    always_comb begin
        cnt_ext  = {1'b0, cnt_q};
        at_top   = (cnt_ext == TOP_EXT);
        at_bot   = (cnt_q == '0);
        // the wide add/sub never overflows; the branch below discards the
        // boundary case, so truncating back to WIDTH bits is exact
        inc_val  = WIDTH'(cnt_ext + WP1'(1));
        dec_val  = WIDTH'(cnt_ext - WP1'(1));
        boundary = bus.up ? at_top : at_bot;
        tick     = bus.en && (pre_q == PRE_LAST);

`ifdef MOD_COUNTER_SAT_EN
        // a step at either end is blocked: the count stays put
        bnd_up_val = cnt_q;
        bnd_dn_val = cnt_q;
`else
        // a step at either end wraps to the opposite end of the range
        bnd_up_val = '0;
        bnd_dn_val = TOP;
`endif

        if (bus.up) begin
            next_cnt = at_top ? bnd_up_val : inc_val;
        end else begin
            next_cnt = at_bot ? bnd_dn_val : dec_val;
        end

        // out-of-range load values land on the top of the range
        load_clamped = ({1'b0, bus.load_val} > TOP_EXT) ? TOP : bus.load_val;
    end

    // next-state selection: clear beats load beats a prescaled step
    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
            pre_d = '0;
        end else if (bus.load) begin
            cnt_d = load_clamped;
            pre_d = '0;
        end else begin
            if (bus.en) begin
                pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            end
            if (tick) begin
                cnt_d  = next_cnt;
                // flags the wrapped step, or the blocked step when saturating
                wrap_d = boundary;
            end
        end
    end

    // state registers; reset clears immediately without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.next_cnt = next_cnt;
    assign bus.tick     = tick;
    assign bus.done     = boundary;
    assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: four counter instances driven by shared controls, checked
// against a behavioural model plus hand-derived sequences.
module tb_mod_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en, up, clr, load;
    logic [3:0] lv;

    // d0: defaults, d1: W4/M10, d2: W4/M10/P3, d3: W1/M2
    mod_counter_if #(.WIDTH(3)) b0 ();
    mod_counter_if #(.WIDTH(4)) b1 ();
    mod_counter_if #(.WIDTH(4)) b2 ();
    mod_counter_if #(.WIDTH(1)) b3 ();

    assign b0.en = en; assign b0.up = up; assign b0.clr = clr; assign b0.load = load; assign b0.load_val = lv[2:0];
    assign b1.en = en; assign b1.up = up; assign b1.clr = clr; assign b1.load = load; assign b1.load_val = lv;
    assign b2.en = en; assign b2.up = up; assign b2.clr = clr; assign b2.load = load; assign b2.load_val = lv;
    assign b3.en = en; assign b3.up = up; assign b3.clr = clr; assign b3.load = load; assign b3.load_val = lv[0];

    mod_counter #(.WIDTH(3), .MODULO(8),  .PRESCALE(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mod_counter #(.WIDTH(1), .MODULO(2),  .PRESCALE(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    logic [3:0] o_cnt  [4];
    logic [3:0] o_next [4];
    logic       o_tick [4];
    logic       o_done [4];
    logic       o_wrap [4];

    assign o_cnt[0] = {1'b0, b0.cnt}; assign o_next[0] = {1'b0, b0.next_cnt};
    assign o_cnt[1] = b1.cnt;         assign o_next[1] = b1.next_cnt;
    assign o_cnt[2] = b2.cnt;         assign o_next[2] = b2.next_cnt;
    assign o_cnt[3] = {3'b0, b3.cnt}; assign o_next[3] = {3'b0, b3.next_cnt};
    assign o_tick[0] = b0.tick; assign o_done[0] = b0.done; assign o_wrap[0] = b0.wrap;
    assign o_tick[1] = b1.tick; assign o_done[1] = b1.done; assign o_wrap[1] = b1.wrap;
    assign o_tick[2] = b2.tick; assign o_done[2] = b2.done; assign o_wrap[2] = b2.wrap;
    assign o_tick[3] = b3.tick; assign o_done[3] = b3.done; assign o_wrap[3] = b3.wrap;

    int WIDS [4] = '{3, 4, 4, 1};
    int MODS [4] = '{8, 10, 10, 2};
    int PRES [4] = '{1, 1, 3, 1};

`ifdef MOD_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // behavioural model state
    int m_cnt [4];
    int m_pre [4];
    bit m_wrap[4];

    typedef struct {
        int k;
        int cnt;
        bit wrap;
    } exp_t;
    exp_t sbq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, int k, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[d%0d]: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    function automatic int m_next(int k);
        int c = m_cnt[k];
        int m = MODS[k];
        if (up) return (c == m - 1) ? (SAT ? c : 0) : c + 1;
        return (c == 0) ? (SAT ? c : m - 1) : c - 1;
    endfunction

    function automatic bit m_tick(int k);
        return en && (m_pre[k] == PRES[k] - 1);
    endfunction

    function automatic bit m_done(int k);
        return up ? (m_cnt[k] == MODS[k] - 1) : (m_cnt[k] == 0);
    endfunction

    task automatic model_step(int k, output exp_t e);
        int lvk = int'(lv) & ((1 << WIDS[k]) - 1);
        int nxt = m_next(k);
        bit tk  = m_tick(k);
        bit bnd = m_done(k);
        if (clr) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
        end else if (load) begin
            m_cnt[k] = (lvk > MODS[k] - 1) ? MODS[k] - 1 : lvk;
            m_pre[k] = 0; m_wrap[k] = 0;
        end else begin
            if (en) m_pre[k] = (m_pre[k] == PRES[k] - 1) ? 0 : m_pre[k] + 1;
            if (tk) begin
                m_wrap[k] = bnd;
                m_cnt[k]  = nxt;
            end else begin
                m_wrap[k] = 0;
            end
        end
        e.k = k; e.cnt = m_cnt[k]; e.wrap = m_wrap[k];
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
        end
        sbq.delete();
    endtask

    // one clock: check combinational outputs, push model prediction, compare after the edge
    task automatic cycle(string tag);
        exp_t e;
        #1;
        for (int k = 0; k < 4; k++) begin
            check({tag, ".next"}, k, int'(o_next[k]), m_next(k));
            check({tag, ".tick"}, k, int'(o_tick[k]), int'(m_tick(k)));
            check({tag, ".done"}, k, int'(o_done[k]), int'(m_done(k)));
            model_step(k, e);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, ".cnt"},  e.k, int'(o_cnt[e.k]),  e.cnt);
            check({tag, ".wrap"}, e.k, int'(o_wrap[e.k]), int'(e.wrap));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0; lv = 4'd0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst.cnt",  k, int'(o_cnt[k]),  0);
            check("rst.wrap", k, int'(o_wrap[k]), 0);
            check("rst.next", k, int'(o_next[k]), 1);
            check("rst.done", k, int'(o_done[k]), 0);
            check("rst.tick", k, int'(o_tick[k]), int'(PRES[k] == 1));
        end
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         en, up, clr, load;
        logic [3:0] lv;
        int         n;
        string      tag;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1, 1, 0, 0, 4'd0,  20, "t_up"};
        tbl[1] = '{0, 1, 0, 0, 4'd0,   5, "t_hold"};
        tbl[2] = '{1, 1, 0, 0, 4'd0,   4, "t_resume"};
        tbl[3] = '{1, 0, 0, 0, 4'd0,  25, "t_down"};
        tbl[4] = '{1, 0, 0, 1, 4'd12,  1, "t_load12"};
        tbl[5] = '{1, 1, 1, 1, 4'd12,  1, "t_ldclr"};
        tbl[6] = '{1, 1, 0, 0, 4'd0,  10, "t_mixed"};
        tbl[7] = '{1, 0, 0, 1, 4'd5,   1, "t_load5"};
        tbl[8] = '{1, 0, 0, 0, 4'd0,   3, "t_dn3"};
        tbl[9] = '{1, 1, 0, 0, 4'd0,   7, "t_up7"};

        // free-running up count, prescaler phase and hold
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle("up");
`ifndef MOD_COUNTER_SAT_EN
            check("seq_up.cnt",  0, int'(o_cnt[0]),  (i + 1) % 8);
            check("seq_up.wrap", 0, int'(o_wrap[0]), int'((i + 1) % 8 == 0));
            check("seq_up.done", 0, int'(o_done[0]), int'((i + 1) % 8 == 7));
            check("seq_b2b.cnt", 3, int'(o_cnt[3]),  (i + 1) % 2);
            check("seq_b2b.wrap", 3, int'(o_wrap[3]), int'((i + 1) % 2 == 0));
`endif
            check("seq_pre.cnt",  2, int'(o_cnt[2]),  (i + 1) / 3);
            check("seq_pre.tick", 2, int'(o_tick[2]), int'((i + 1) % 3 == 2));
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle("hold");
            check("seq_hold.cnt",  2, int'(o_cnt[2]),  6);
            check("seq_hold.tick", 2, int'(o_tick[2]), 0);
        end
        en = 1'b1;
        #1;
        check("seq_phase.tick", 2, int'(o_tick[2]), 1);
        cycle("resume");
        check("seq_phase.cnt", 2, int'(o_cnt[2]), 7);

`ifndef MOD_COUNTER_SAT_EN
        // down count from reset wraps 0 -> 9
        do_reset();
        up = 1'b0;
        for (int i = 0; i < 12; i++) begin
            int exp_c;
            cycle("down");
            exp_c = (10 - (i + 1) % 10) % 10;
            check("seq_dn.cnt",  1, int'(o_cnt[1]),  exp_c);
            check("seq_dn.wrap", 1, int'(o_wrap[1]), int'(exp_c == 9));
            check("seq_dn.done", 1, int'(o_done[1]), int'(exp_c == 0));
        end
`endif

        // load against a pending tick, clamp, clear priority, done after load
        do_reset();
        for (int i = 0; i < 9; i++) cycle("pre_ld");
        check("seq_ld.at9",  1, int'(o_cnt[1]),  9);
        check("seq_ld.done", 1, int'(o_done[1]), 1);
        load = 1'b1; lv = 4'd3;
        cycle("ld_tick");
        check("seq_ld.cnt",  1, int'(o_cnt[1]),  3);
        check("seq_ld.wrap", 1, int'(o_wrap[1]), 0);
        lv = 4'd12;
        cycle("ld_clamp");
        check("seq_clamp.cnt", 1, int'(o_cnt[1]), 9);
        check("seq_clamp.cnt", 0, int'(o_cnt[0]), 4);
        clr = 1'b1;
        cycle("ld_clr");
        check("seq_ldclr.cnt", 1, int'(o_cnt[1]), 0);
        clr = 1'b0; lv = 4'd9; en = 1'b0;
        cycle("ld_top");
        load = 1'b0;
        #1;
        check("seq_ldtop.done", 1, int'(o_done[1]), 1);

        // asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 5; i++) cycle("pre_rst");
        check("seq_arst.at5", 0, int'(o_cnt[0]), 5);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("seq_arst.cnt",  k, int'(o_cnt[k]),  0);
            check("seq_arst.wrap", k, int'(o_wrap[k]), 0);
        end
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("arst_r1");
        cycle("arst_r2");
        check("seq_arst.p2", 2, int'(o_cnt[2]), 0);
        cycle("arst_r3");
        check("seq_arst.p3", 2, int'(o_cnt[2]), 1);

`ifdef MOD_COUNTER_SAT_EN
        // saturate at top, then count down and stick at zero
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle("sat_up");
            check("seq_sat.cnt",  0, int'(o_cnt[0]),  (i + 1 > 7) ? 7 : i + 1);
            check("seq_sat.wrap", 0, int'(o_wrap[0]), int'(i >= 7));
        end
        up = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle("sat_dn");
            check("seq_satd.cnt",  0, int'(o_cnt[0]),  (6 - i < 0) ? 0 : 6 - i);
            check("seq_satd.wrap", 0, int'(o_wrap[0]), int'(i >= 7));
        end
`endif

        // table-driven mixed stimulus against the model
        do_reset();
        for (int r = 0; r < 10; r++) begin
            en = tbl[r].en; up = tbl[r].up; clr = tbl[r].clr;
            load = tbl[r].load; lv = tbl[r].lv;
            for (int j = 0; j < tbl[r].n; j++) cycle(tbl[r].tag);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
